// File: rtl/pong_ball_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_ball_engine_if
//  Description : Bundle between the game controller side (tick divider,
//                serve button, paddle positions) and the ball engine, plus
//                the ball/score outputs consumed by the renderer.
//  Revision    : 1.0  initial release
// ============================================================================
interface pong_ball_engine_if;
  logic       tick;
  logic       serve;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       point_l;
  logic       point_r;
  logic       playing;
  logic       game_over;

  // Controller side: drives strobes and paddles, observes the ball
  modport master (
    output tick, serve, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, score_l, score_r, point_l, point_r, playing, game_over
  );

  // Engine side
  modport slave (
    input  tick, serve, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, score_l, score_r, point_l, point_r, playing, game_over
  );
endinterface
`default_nettype wire

// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pong_ball_engine
//  Description : Advances the ball one step per frame tick, bounces it off
//                walls and paddles, detects points, keeps score and holds
//                the ball frozen for a while after each point.
//  Revision    : 1.0  initial release
// ============================================================================
module pong_ball_engine #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int BALL_SIZE  = 8,
  parameter int STEP       = 4,
  parameter int PADDLE_H   = 64,
  parameter int PADDLE_W   = 8,
  parameter int PADDLE_L_X = 16,
  parameter int PADDLE_R_X = 616,
  parameter int HOLD_TICKS = 30,
  parameter int MAX_SCORE  = 9
) (
  input  logic               clock,
  input  logic               reset,
  pong_ball_engine_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  // All positional maths is carried one bit wider so sums never wrap.
  localparam logic [10:0] c_step     = 11'(STEP);
  localparam logic [10:0] c_ball     = 11'(BALL_SIZE);
  localparam logic [10:0] c_pad_h    = 11'(PADDLE_H);
  localparam logic [10:0] c_h_res    = 11'(H_RES);
  localparam logic [10:0] c_y_max    = 11'(V_RES - BALL_SIZE);
  localparam logic [10:0] c_r_face   = 11'(PADDLE_R_X);
  localparam logic [10:0] c_r_clamp  = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic [10:0] c_l_face   = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic [9:0]  c_x_centre = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [9:0]  c_y_centre = 10'((V_RES - BALL_SIZE) / 2);
  localparam logic [3:0]  c_max      = 4'(MAX_SCORE);
  localparam int          c_hold_w   = $clog2(HOLD_TICKS + 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_TICKS - 1);

  state_t              state_q, state_d;
  logic [9:0]          x_q, x_d, y_q, y_d;
  logic                dx_q, dx_d;        // 1: moving toward +x
  logic                dy_q, dy_d;        // 1: moving toward +y
  logic [3:0]          score_l_q, score_l_d, score_r_q, score_r_d;
  logic                point_l_q, point_l_d, point_r_q, point_r_d;
  logic [c_hold_w-1:0] hold_q, hold_d;

  logic [10:0] w_x, w_y, w_pl, w_pr;
  logic [10:0] w_x_mv, w_y_mv;
  logic        w_dx_mv, w_dy_mv;
  logic        w_ovl_l, w_ovl_r;
  logic        w_miss_r, w_miss_l;        // ball passed the right / left paddle
  logic [3:0]  w_score_l_inc, w_score_r_inc;

  // Candidate move for one tick, plus point detection, from current state
  always_comb begin
    w_x  = {1'b0, x_q};
    w_y  = {1'b0, y_q};
    w_pl = {1'b0, bus.paddle_l_y};
    w_pr = {1'b0, bus.paddle_r_y};

    w_ovl_l = (w_y + c_ball > w_pl) && (w_y < w_pl + c_pad_h);
    w_ovl_r = (w_y + c_ball > w_pr) && (w_y < w_pr + c_pad_h);

    w_y_mv  = w_y;
    w_dy_mv = dy_q;
    if (!dy_q) begin
      if (w_y <= c_step) begin
        w_y_mv  = 11'd0;
        w_dy_mv = 1'b1;
      end else begin
        w_y_mv = w_y - c_step;
      end
    end else begin
      if (w_y + c_step >= c_y_max) begin
        w_y_mv  = c_y_max;
        w_dy_mv = 1'b0;
      end else begin
        w_y_mv = w_y + c_step;
      end
    end

    w_x_mv   = w_x;
    w_dx_mv  = dx_q;
    w_miss_r = 1'b0;
    w_miss_l = 1'b0;
    if (dx_q) begin
      if ((w_x + c_ball <= c_r_face) && (w_x + c_ball + c_step >= c_r_face) && w_ovl_r) begin
        w_x_mv  = c_r_clamp;
        w_dx_mv = 1'b0;
      end else if (w_x + c_ball + c_step >= c_h_res) begin
        w_miss_r = 1'b1;
      end else begin
        w_x_mv = w_x + c_step;
      end
    end else begin
      if ((w_x >= c_l_face) && (w_x <= c_l_face + c_step) && w_ovl_l) begin
        w_x_mv  = c_l_face;
        w_dx_mv = 1'b1;
      end else if (w_x < c_step) begin
        w_miss_l = 1'b1;
      end else begin
        w_x_mv = w_x - c_step;
      end
    end

    w_score_l_inc = (score_l_q >= c_max) ? score_l_q : score_l_q + 4'd1;
    w_score_r_inc = (score_r_q >= c_max) ? score_r_q : score_r_q + 4'd1;
  end

  // Next-state logic: game flow, ball update and scoring
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    point_l_d = 1'b0;
    point_r_d = 1'b0;
    hold_d    = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.serve) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.tick) begin
          if (w_miss_r) begin
            // Left scores; next serve heads toward the right player
            point_l_d = 1'b1;
            score_l_d = w_score_l_inc;
            dx_d      = 1'b1;
            hold_d    = '0;
            state_d   = (w_score_l_inc == c_max) ? ST_OVER : ST_SCORED;
          end else if (w_miss_l) begin
            point_r_d = 1'b1;
            score_r_d = w_score_r_inc;
            dx_d      = 1'b0;
            hold_d    = '0;
            state_d   = (w_score_r_inc == c_max) ? ST_OVER : ST_SCORED;
          end else begin
            x_d  = w_x_mv[9:0];
            dx_d = w_dx_mv;
            y_d  = w_y_mv[9:0];
            dy_d = w_dy_mv;
          end
        end
      end
      ST_SCORED: begin
        if (bus.tick) begin
          if (hold_q == c_hold_last) begin
            hold_d  = '0;
            x_d     = c_x_centre;
            y_d     = c_y_centre;
            dy_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_OVER;
      end
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= c_x_centre;
      y_q       <= c_y_centre;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.ball_x    = x_q;
  assign bus.ball_y    = y_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.point_l   = point_l_q;
  assign bus.point_r   = point_r_q;
  assign bus.playing   = (state_q == ST_PLAY);
  assign bus.game_over = (state_q == ST_OVER);

endmodule
`default_nettype wire
